// File: rtl/scan_multiplexer.sv
// scan_multiplexer: registered N-channel multiplexer with manual select and
// round-robin scan mode. The scan mode spends DWELL enabled cycles on each
// channel. Outputs carry the channel tag, a valid strobe, a wrap pulse and a
// select-range error flag.
module scan_multiplexer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned DWELL     = 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
  input  logic [SEL_WIDTH-1:0]      SELECT,
  input  logic                      MODE,
  input  logic                      ENABLE,
  output logic [WIDTH-1:0]          DATA_OUT,
  output logic [SEL_WIDTH-1:0]      CHANNEL_OUT,
  output logic                      VALID,
  output logic                      WRAP,
  output logic                      SEL_ERR
);

  localparam logic [15:0]          DWELL_LAST = 16'(DWELL - 1);
  localparam logic [SEL_WIDTH-1:0] PTR_LAST   = SEL_WIDTH'(CHANNELS - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_WIDTH-1:0] chan_q, chan_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;

  logic                 entering_scan;
  logic [SEL_WIDTH-1:0] ptr_eff;
  logic [15:0]          cnt_eff;
  logic [SEL_WIDTH-1:0] idx;
  logic [WIDTH-1:0]     chan_data;
  logic                 sel_oob;

  // Effective pointer/counter and channel index for the sample on this edge.
  // The scan pointer clears on the same edge that enters scan, so the first
  // scan sample is taken from channel 0 with the dwell counter at 0.
  always_comb begin
    entering_scan = MODE && (state_q == MANUAL);
    ptr_eff       = entering_scan ? '0 : ptr_q;
    cnt_eff       = entering_scan ? '0 : cnt_q;
    idx           = MODE ? ptr_eff : SELECT;
    sel_oob       = (32'(SELECT) >= CHANNELS);
  end

  // Channel mux; an index beyond the last channel matches nothing and gives 0.
  always_comb begin
    chan_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(idx) == k) begin
        chan_data = DATA_IN[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and output logic: FSM follows MODE; datapath updates when enabled.
  always_comb begin
    state_d = MODE ? SCAN : MANUAL;
    ptr_d   = ptr_eff;
    cnt_d   = cnt_eff;
    data_d  = data_q;
    chan_d  = chan_q;
    err_d   = err_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (ENABLE) begin
      data_d  = chan_data;
      chan_d  = idx;
      valid_d = 1'b1;
      if (MODE) begin
        err_d = 1'b0;
        if (cnt_eff == DWELL_LAST) begin
          cnt_d = '0;
          if (ptr_eff == PTR_LAST) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_eff + SEL_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_eff + 16'd1;
        end
      end else begin
        err_d = sel_oob;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= MANUAL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign DATA_OUT    = data_q;
  assign CHANNEL_OUT = chan_q;
  assign VALID       = valid_q;
  assign WRAP        = wrap_q;
  assign SEL_ERR     = err_q;

endmodule

// File: tb/tb_scan_multiplexer.sv
// Testbench for scan_multiplexer: one 4-channel instance (DWELL=2) and one
// 3-channel instance (DWELL=1) driven from shared controls; expected outputs
// are queued with each stimulus cycle and compared after the edge.
module tb_scan_multiplexer;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
    logic       err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MODE;
  logic        ENABLE;
  logic [1:0]  SELECT;
  logic [15:0] data_a = 16'hDCBA;
  logic [11:0] data_b = 12'hCBA;

  logic [3:0] out_a, out_b;
  logic [1:0] ch_a, ch_b;
  logic       valid_a, valid_b, wrap_a, wrap_b, err_a, err_b;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 CLK = ~CLK;

  scan_multiplexer #(.WIDTH(4), .CHANNELS(4), .SEL_WIDTH(2), .DWELL(2)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(data_a), .SELECT(SELECT),
    .MODE(MODE), .ENABLE(ENABLE), .DATA_OUT(out_a), .CHANNEL_OUT(ch_a),
    .VALID(valid_a), .WRAP(wrap_a), .SEL_ERR(err_a)
  );

  scan_multiplexer #(.WIDTH(4), .CHANNELS(3), .SEL_WIDTH(2), .DWELL(1)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(data_b), .SELECT(SELECT),
    .MODE(MODE), .ENABLE(ENABLE), .DATA_OUT(out_b), .CHANNEL_OUT(ch_b),
    .VALID(valid_b), .WRAP(wrap_b), .SEL_ERR(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic [1:0] c,
                              input logic v, input logic w, input logic e);
    exp_t r;
    r.data = d; r.ch = c; r.valid = v; r.wrap = w; r.err = e;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input bit use_b, input logic rstn,
                      input logic mode, input logic en, input logic [1:0] sel,
                      input exp_t e);
    exp_t x;
    RESET_N = rstn; MODE = mode; ENABLE = en; SELECT = sel;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      if (use_b) begin
        check({tag, "/data"},  32'(out_b),   32'(x.data));
        check({tag, "/ch"},    32'(ch_b),    32'(x.ch));
        check({tag, "/valid"}, 32'(valid_b), 32'(x.valid));
        check({tag, "/wrap"},  32'(wrap_b),  32'(x.wrap));
        check({tag, "/err"},   32'(err_b),   32'(x.err));
      end else begin
        check({tag, "/data"},  32'(out_a),   32'(x.data));
        check({tag, "/ch"},    32'(ch_a),    32'(x.ch));
        check({tag, "/valid"}, 32'(valid_a), 32'(x.valid));
        check({tag, "/wrap"},  32'(wrap_a),  32'(x.wrap));
        check({tag, "/err"},   32'(err_a),   32'(x.err));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges with ENABLE high
    step("rst0", 0, 0, 0, 1, 2'd2, mk(4'h0, 2'd0, 0, 0, 0));
    step("rst1", 0, 0, 0, 1, 2'd2, mk(4'h0, 2'd0, 0, 0, 0));
    check("rst_b/data", 32'(out_b), 32'd0);
    check("rst_b/valid", 32'(valid_b), 32'd0);

    // Manual sweep
    step("man0", 0, 1, 0, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("man1", 0, 1, 0, 1, 2'd1, mk(4'hB, 2'd1, 1, 0, 0));
    step("man2", 0, 1, 0, 1, 2'd2, mk(4'hC, 2'd2, 1, 0, 0));
    step("man3", 0, 1, 0, 1, 2'd3, mk(4'hD, 2'd3, 1, 0, 0));
    // Manual hold with ENABLE low
    step("manhold", 0, 1, 0, 0, 2'd0, mk(4'hD, 2'd3, 0, 0, 0));

    // Scan with DWELL=2: one full period then the first sample of the next
    step("scan1", 0, 1, 1, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("scan2", 0, 1, 1, 1, 2'd3, mk(4'hA, 2'd0, 1, 0, 0));
    step("scan3", 0, 1, 1, 1, 2'd0, mk(4'hB, 2'd1, 1, 0, 0));
    step("scan4", 0, 1, 1, 1, 2'd0, mk(4'hB, 2'd1, 1, 0, 0));
    step("scan5", 0, 1, 1, 1, 2'd0, mk(4'hC, 2'd2, 1, 0, 0));
    step("scan6", 0, 1, 1, 1, 2'd0, mk(4'hC, 2'd2, 1, 0, 0));
    step("scan7", 0, 1, 1, 1, 2'd0, mk(4'hD, 2'd3, 1, 0, 0));
    step("scan8", 0, 1, 1, 1, 2'd0, mk(4'hD, 2'd3, 1, 1, 0));
    step("scan9", 0, 1, 1, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("scan10", 0, 1, 1, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("scan11", 0, 1, 1, 1, 2'd0, mk(4'hB, 2'd1, 1, 0, 0));

    // Freeze for three cycles after the first B, then resume
    for (int i = 0; i < 3; i++) begin
      step("freeze", 0, 1, 1, 0, 2'd0, mk(4'hB, 2'd1, 0, 0, 0));
    end
    step("resume0", 0, 1, 1, 1, 2'd0, mk(4'hB, 2'd1, 1, 0, 0));
    step("resume1", 0, 1, 1, 1, 2'd0, mk(4'hC, 2'd2, 1, 0, 0));

    // Reset mid-scan (pointer at 2), then scanning restarts at channel 0
    step("midrst", 0, 0, 1, 1, 2'd0, mk(4'h0, 2'd0, 0, 0, 0));
    step("restart0", 0, 1, 1, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("restart1", 0, 1, 1, 1, 2'd0, mk(4'hA, 2'd0, 1, 0, 0));
    step("restart2", 0, 1, 1, 1, 2'd0, mk(4'hB, 2'd1, 1, 0, 0));

    // Scan to manual takes effect on the same edge
    step("tomanual", 0, 1, 0, 1, 2'd3, mk(4'hD, 2'd3, 1, 0, 0));
    // Entering scan with ENABLE low still clears the pointer
    step("enter_dis", 0, 1, 1, 0, 2'd3, mk(4'hD, 2'd3, 0, 0, 0));
    step("enter_en", 0, 1, 1, 1, 2'd3, mk(4'hA, 2'd0, 1, 0, 0));

    // Three-channel instance: out-of-range select, hold, clear
    step("selerr", 1, 1, 0, 1, 2'd3, mk(4'h0, 2'd3, 1, 0, 1));
    step("selhold", 1, 1, 0, 0, 2'd1, mk(4'h0, 2'd3, 0, 0, 1));
    step("selok", 1, 1, 0, 1, 2'd1, mk(4'hB, 2'd1, 1, 0, 0));
    step("selerr2", 1, 1, 0, 1, 2'd3, mk(4'h0, 2'd3, 1, 0, 1));
    // Scan clears the error; non-power-of-two wrap after channel 2
    step("b_scan0", 1, 1, 1, 1, 2'd3, mk(4'hA, 2'd0, 1, 0, 0));
    step("b_scan1", 1, 1, 1, 1, 2'd3, mk(4'hB, 2'd1, 1, 0, 0));
    step("b_scan2", 1, 1, 1, 1, 2'd3, mk(4'hC, 2'd2, 1, 1, 0));
    step("b_scan3", 1, 1, 1, 1, 2'd3, mk(4'hA, 2'd0, 1, 0, 0));
    step("b_scan4", 1, 1, 1, 1, 2'd3, mk(4'hB, 2'd1, 1, 0, 0));

    if (sb.size() != 0) begin
      check("sb_leftover", 32'(sb.size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_multiplexer.md
# scan_multiplexer

Parametrised, registered N-channel multiplexer; the clocked successor to the team's combinational 4:1 mux. It selects one WIDTH-bit channel either from an external SELECT (manual mode) or from an internal channel pointer that steps round-robin through all channels with a programmable dwell (scan mode). It sits between a bank of sampled data sources and a single downstream consumer, and delivers registered data with channel tag, valid and wrap indications.

## Interface
- WIDTH, 4: bits per channel.
- CHANNELS, 4: number of input channels, 2..256.
- SEL_WIDTH, 2: width of SELECT and CHANNEL_OUT; must satisfy 2^SEL_WIDTH >= CHANNELS.
- DWELL, 1: enabled cycles spent on each channel in scan mode, 1..65535.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  synchronous, active-low reset, sampled on CLK rising edge.
- DATA_IN  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- SELECT  in  SEL_WIDTH  channel index in manual mode; ignored in scan mode.
- MODE  in  1  0 = manual, 1 = scan.
- ENABLE  in  1  sample/advance qualifier.
- DATA_OUT  out  WIDTH  registered selected channel data.
- CHANNEL_OUT  out  SEL_WIDTH  index of the channel currently held in DATA_OUT.
- VALID  out  1  DATA_OUT/CHANNEL_OUT updated on the previous edge.
- WRAP  out  1  one-cycle pulse: last dwell sample of channel CHANNELS-1 is on DATA_OUT.
- SEL_ERR  out  1  manual-mode SELECT >= CHANNELS on the last enabled sample.

## Operation
- Reset (RESET_N=0 at an edge): DATA_OUT=0, CHANNEL_OUT=0, VALID=0, WRAP=0, SEL_ERR=0, pointer=0, dwell counter=0, FSM=MANUAL. Reset overrides ENABLE and MODE, including mid-scan.
- FSM states: MANUAL, SCAN. The FSM goes to the MODE value on each edge. On a MANUAL->SCAN transition, the pointer and dwell counter clear to 0. SCAN->MANUAL takes effect on the same edge MODE is sampled.
- MODE is evaluated per edge. The sample taken on an edge uses the MODE sampled on that edge.
- Manual, ENABLE=1: DATA_OUT <= channel[SELECT], CHANNEL_OUT <= SELECT, VALID <= 1, WRAP <= 0. If SELECT >= CHANNELS: DATA_OUT <= 0, CHANNEL_OUT <= SELECT, SEL_ERR <= 1; otherwise SEL_ERR <= 0.
- Scan, ENABLE=1: DATA_OUT <= channel[pointer], CHANNEL_OUT <= pointer, VALID <= 1, SEL_ERR <= 0.
  - If dwell counter = DWELL-1: counter <= 0 and the pointer advances. When pointer = CHANNELS-1, the pointer wraps to 0 and WRAP <= 1.
  - Otherwise: counter increments and WRAP <= 0.
- ENABLE=0 (either mode): DATA_OUT, CHANNEL_OUT, SEL_ERR hold; VALID <= 0; WRAP <= 0; pointer and dwell counter freeze.
- Entering scan with ENABLE=0: the pointer still clears to 0.
- Non-power-of-two CHANNELS: the pointer never reaches values >= CHANNELS.

## Timing
- Latency: 1 cycle from sampling edge to DATA_OUT/VALID.
- No backpressure: the consumer must accept every VALID cycle.
- Scan period: CHANNELS*DWELL enabled cycles. WRAP asserts exactly once per period, coincident with VALID.
- DATA_IN is sampled only at enabled edges. Changes between edges are not visible.
- Release from reset: the first sample occurs on the first edge with RESET_N=1 and ENABLE=1.

## Test plan
- Reset: with WIDTH=4, CHANNELS=4, drive RESET_N=0 for 2 edges while ENABLE=1 -> DATA_OUT=0, CHANNEL_OUT=0, VALID=0, WRAP=0, SEL_ERR=0.
- Manual sweep: DATA_IN=16'hDCBA, MODE=0, ENABLE=1, SELECT 0,1,2,3 on successive edges -> DATA_OUT A,B,C,D one cycle later, with matching CHANNEL_OUT and VALID=1 throughout.
- Scan with dwell: DWELL=2, MODE=1, ENABLE=1 for 8 edges -> DATA_OUT A,A,B,B,C,C,D,D; CHANNEL_OUT 0,0,1,1,2,2,3,3; WRAP=1 only on the 8th output; the 9th output is A.
- Freeze: in scan with DWELL=2, drop ENABLE for 3 cycles after the first B -> VALID=0, DATA_OUT holds B; on resume the next outputs are B then C.
- Select error: CHANNELS=3, SEL_WIDTH=2, manual SELECT=3 -> DATA_OUT=0, CHANNEL_OUT=3, SEL_ERR=1. The next SELECT=1 clears SEL_ERR.
- Reset mid-scan: pulse RESET_N=0 for one edge while the pointer is at 2 -> all outputs return to 0 and FSM=MANUAL. With MODE held at 1, scanning restarts at channel 0.
